// File: rtl/fu_wb_arbiter_if.sv
// Bundle of FU result channels and the single writeback/ROB completion port.
// slave is the arbiter's view; master is the view of the FUs plus the writeback consumer.
interface fu_wb_arbiter_if #(
    parameter int NUM_FU       = 4,
    parameter int INST_ID_BITS = 6,
    parameter int PRN_BITS     = 6,
    parameter int MAX_OPERANDS = 3
);
    localparam int SRC_W = $clog2(NUM_FU);

    logic [NUM_FU-1:0]                                  fu_valid;
    logic [NUM_FU-1:0]                                  fu_ready;
    logic [NUM_FU-1:0][INST_ID_BITS-1:0]                fu_inst_id;
    logic [NUM_FU-1:0][MAX_OPERANDS-1:0][PRN_BITS-1:0]  fu_prn;
    logic [NUM_FU-1:0][MAX_OPERANDS-1:0][63:0]          fu_data;
    logic [NUM_FU-1:0][MAX_OPERANDS-1:0]                fu_data_valid;

    logic                                               wb_valid;
    logic                                               wb_ready;
    logic [INST_ID_BITS-1:0]                            wb_inst_id;
    logic [MAX_OPERANDS-1:0][PRN_BITS-1:0]              wb_prn;
    logic [MAX_OPERANDS-1:0][63:0]                      wb_data;
    logic [MAX_OPERANDS-1:0]                            wb_data_valid;
    logic [SRC_W-1:0]                                   wb_src;

    modport master (
        output fu_valid, fu_inst_id, fu_prn, fu_data, fu_data_valid, wb_ready,
        input  fu_ready, wb_valid, wb_inst_id, wb_prn, wb_data, wb_data_valid, wb_src
    );

    modport slave (
        input  fu_valid, fu_inst_id, fu_prn, fu_data, fu_data_valid, wb_ready,
        output fu_ready, wb_valid, wb_inst_id, wb_prn, wb_data, wb_data_valid, wb_src
    );
endinterface

// File: rtl/fu_wb_arbiter.sv
// Per-FU result FIFOs feeding one writeback port through a round-robin arbiter.
// The grant is held while the consumer stalls, so the presented result never changes under backpressure.
module fu_wb_arbiter #(
    parameter int NUM_FU       = 4,
    parameter int FIFO_DEPTH   = 2,
    parameter int INST_ID_BITS = 6,
    parameter int PRN_BITS     = 6,
    parameter int MAX_OPERANDS = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic flush,
    fu_wb_arbiter_if.slave bus
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int SRC_W = $clog2(NUM_FU);

    logic [INST_ID_BITS-1:0]               mem_inst [NUM_FU][FIFO_DEPTH];
    logic [MAX_OPERANDS-1:0][PRN_BITS-1:0] mem_prn  [NUM_FU][FIFO_DEPTH];
    logic [MAX_OPERANDS-1:0][63:0]         mem_data [NUM_FU][FIFO_DEPTH];
    logic [MAX_OPERANDS-1:0]               mem_dv   [NUM_FU][FIFO_DEPTH];

    logic [PTR_W-1:0] wr_ptr [NUM_FU];
    logic [PTR_W-1:0] rd_ptr [NUM_FU];
    logic [CNT_W-1:0] count  [NUM_FU];

    logic [SRC_W-1:0]  rr_ptr;
    logic [SRC_W-1:0]  lock_src;
    logic              lock;

    logic [NUM_FU-1:0] ready;
    logic [NUM_FU-1:0] nonempty;
    logic [NUM_FU-1:0] push;
    logic [NUM_FU-1:0] pop;
    logic [SRC_W-1:0]  grant;
    logic [SRC_W-1:0]  scan_idx;
    logic              found;
    logic              any_valid;

    // Ready comes from the registered count only, so a full channel stays closed even during a pop.
    always_comb begin
        for (int n = 0; n < NUM_FU; n++) begin
            ready[n]    = count[n] < CNT_W'(FIFO_DEPTH);
            nonempty[n] = count[n] != '0;
            push[n]     = bus.fu_valid[n] & ready[n];
        end
    end

    assign bus.fu_ready = ready;
    assign any_valid    = |nonempty;

    always_comb begin
        grant    = rr_ptr;
        scan_idx = '0;
        found    = 1'b0;
        if (lock) begin
            grant = lock_src;
        end else begin
            for (int i = 0; i < NUM_FU; i++) begin
                scan_idx = SRC_W'((int'(rr_ptr) + i) % NUM_FU);
                if (!found && nonempty[scan_idx]) begin
                    grant = scan_idx;
                    found = 1'b1;
                end
            end
        end
    end

    always_comb begin
        for (int n = 0; n < NUM_FU; n++) begin
            pop[n] = any_valid & bus.wb_ready & (grant == SRC_W'(n));
        end
    end

    // Payload and source index are forced to zero whenever nothing is presented.
    always_comb begin
        bus.wb_valid      = any_valid;
        bus.wb_inst_id    = '0;
        bus.wb_prn        = '0;
        bus.wb_data       = '0;
        bus.wb_data_valid = '0;
        bus.wb_src        = '0;
        if (any_valid) begin
            bus.wb_inst_id    = mem_inst[grant][rd_ptr[grant]];
            bus.wb_prn        = mem_prn[grant][rd_ptr[grant]];
            bus.wb_data       = mem_data[grant][rd_ptr[grant]];
            bus.wb_data_valid = mem_dv[grant][rd_ptr[grant]];
            bus.wb_src        = grant;
        end
    end

    always_ff @(posedge clk) begin
        for (int n = 0; n < NUM_FU; n++) begin
            if (push[n] && !flush) begin
                mem_inst[n][wr_ptr[n]] <= bus.fu_inst_id[n];
                mem_prn[n][wr_ptr[n]]  <= bus.fu_prn[n];
                mem_data[n][wr_ptr[n]] <= bus.fu_data[n];
                mem_dv[n][wr_ptr[n]]   <= bus.fu_data_valid[n];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int n = 0; n < NUM_FU; n++) begin
                wr_ptr[n] <= '0;
                rd_ptr[n] <= '0;
                count[n]  <= '0;
            end
            rr_ptr   <= '0;
            lock     <= 1'b0;
            lock_src <= '0;
        end else if (flush) begin
            for (int n = 0; n < NUM_FU; n++) begin
                wr_ptr[n] <= '0;
                rd_ptr[n] <= '0;
                count[n]  <= '0;
            end
            rr_ptr   <= '0;
            lock     <= 1'b0;
            lock_src <= '0;
        end else begin
            for (int n = 0; n < NUM_FU; n++) begin
                if (push[n]) wr_ptr[n] <= wr_ptr[n] + PTR_W'(1);
                if (pop[n])  rd_ptr[n] <= rd_ptr[n] + PTR_W'(1);
                if (push[n] && !pop[n])      count[n] <= count[n] + CNT_W'(1);
                else if (!push[n] && pop[n]) count[n] <= count[n] - CNT_W'(1);
            end
            if (any_valid && bus.wb_ready) begin
                rr_ptr <= (grant == SRC_W'(NUM_FU - 1)) ? '0 : grant + SRC_W'(1);
            end
            lock     <= any_valid & ~bus.wb_ready;
            lock_src <= grant;
        end
    end
endmodule

// File: tb/tb_fu_wb_arbiter.sv
// Randomized and directed bench for fu_wb_arbiter, checked every cycle against a queue-based model.
module tb_fu_wb_arbiter;
    localparam int NUM_FU       = 4;
    localparam int FIFO_DEPTH   = 2;
    localparam int INST_ID_BITS = 6;
    localparam int PRN_BITS     = 6;
    localparam int MAX_OPERANDS = 3;

    typedef struct packed {
        logic [INST_ID_BITS-1:0]               inst_id;
        logic [MAX_OPERANDS-1:0][PRN_BITS-1:0] prn;
        logic [MAX_OPERANDS-1:0][63:0]         data;
        logic [MAX_OPERANDS-1:0]               dv;
    } entry_t;

    logic clk   = 1'b0;
    logic rst   = 1'b0;
    logic flush = 1'b0;

    fu_wb_arbiter_if #(
        .NUM_FU(NUM_FU), .INST_ID_BITS(INST_ID_BITS),
        .PRN_BITS(PRN_BITS), .MAX_OPERANDS(MAX_OPERANDS)
    ) bus ();

    fu_wb_arbiter #(
        .NUM_FU(NUM_FU), .FIFO_DEPTH(FIFO_DEPTH), .INST_ID_BITS(INST_ID_BITS),
        .PRN_BITS(PRN_BITS), .MAX_OPERANDS(MAX_OPERANDS)
    ) dut (
        .clk(clk),
        .rst(rst),
        .flush(flush),
        .bus(bus)
    );

    always #5 clk = ~clk;

    entry_t model_q [NUM_FU][$];
    entry_t stim_q  [NUM_FU][$];
    int     m_rr;
    int     m_lock_src;
    bit     m_lock;
    int     n_checks;
    int     n_fail;

    task automatic checkOutput(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    function automatic entry_t make_entry(input int inst, input logic [63:0] d0, input int p0);
        entry_t e;
        e         = '0;
        e.inst_id = INST_ID_BITS'(inst);
        e.data[0] = d0;
        e.prn[0]  = PRN_BITS'(p0);
        e.dv      = MAX_OPERANDS'(1);
        return e;
    endfunction

    function automatic entry_t rand_entry();
        entry_t e;
        e.inst_id = INST_ID_BITS'($urandom);
        for (int s = 0; s < MAX_OPERANDS; s++) begin
            e.prn[s]  = PRN_BITS'($urandom);
            e.data[s] = {$urandom, $urandom};
        end
        e.dv = MAX_OPERANDS'($urandom);
        return e;
    endfunction

    // Reference grant: held channel while stalled, else first non-empty channel from the RR pointer.
    function automatic int model_grant();
        if (m_lock) return m_lock_src;
        for (int i = 0; i < NUM_FU; i++) begin
            if (model_q[(m_rr + i) % NUM_FU].size() != 0) return (m_rr + i) % NUM_FU;
        end
        return -1;
    endfunction

    function automatic void model_clear();
        for (int n = 0; n < NUM_FU; n++) model_q[n].delete();
        m_rr       = 0;
        m_lock     = 1'b0;
        m_lock_src = 0;
    endfunction

    task automatic applyStimulus();
        for (int n = 0; n < NUM_FU; n++) begin
            if (stim_q[n].size() != 0) begin
                bus.fu_valid[n]      = 1'b1;
                bus.fu_inst_id[n]    = stim_q[n][0].inst_id;
                bus.fu_prn[n]        = stim_q[n][0].prn;
                bus.fu_data[n]       = stim_q[n][0].data;
                bus.fu_data_valid[n] = stim_q[n][0].dv;
            end else begin
                bus.fu_valid[n]      = 1'b0;
                bus.fu_inst_id[n]    = '0;
                bus.fu_prn[n]        = '0;
                bus.fu_data[n]       = '0;
                bus.fu_data_valid[n] = '0;
            end
        end
    endtask

    // One clock: drive, compare on the falling edge, advance the model, return just after the rising edge.
    task automatic run_cycle();
        int               g;
        entry_t           h;
        logic [NUM_FU-1:0] exp_ready;
        logic [NUM_FU-1:0] acc;
        applyStimulus();
        @(negedge clk);
        g = model_grant();
        for (int n = 0; n < NUM_FU; n++) exp_ready[n] = model_q[n].size() < FIFO_DEPTH;
        checkOutput("fu_ready", bus.fu_ready, exp_ready);
        checkOutput("wb_valid", bus.wb_valid, g >= 0);
        h = (g >= 0) ? model_q[g][0] : '0;
        checkOutput("wb_src", bus.wb_src, (g >= 0) ? g : 0);
        checkOutput("wb_payload", {bus.wb_inst_id, bus.wb_prn, bus.wb_data, bus.wb_data_valid}, h);
        for (int n = 0; n < NUM_FU; n++) acc[n] = bus.fu_valid[n] & exp_ready[n];
        if (flush) begin
            model_clear();
        end else begin
            if (g >= 0 && bus.wb_ready) begin
                void'(model_q[g].pop_front());
                m_rr = (g + 1) % NUM_FU;
            end
            for (int n = 0; n < NUM_FU; n++) begin
                if (acc[n]) model_q[n].push_back(stim_q[n][0]);
            end
            m_lock     = (g >= 0) && !bus.wb_ready;
            m_lock_src = g;
        end
        for (int n = 0; n < NUM_FU; n++) begin
            if (acc[n]) void'(stim_q[n].pop_front());
        end
        @(posedge clk);
        #1;
    endtask

    task automatic flush_cycle();
        flush = 1'b1;
        run_cycle();
        flush = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        n_checks     = 0;
        n_fail       = 0;
        bus.wb_ready = 1'b0;
        model_clear();
        applyStimulus();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        checkOutput("reset_wb_valid", bus.wb_valid, 1'b0);
        checkOutput("reset_fu_ready", bus.fu_ready, 4'hF);
        checkOutput("reset_wb_src", bus.wb_src, 0);
        run_cycle();

        $display("[TB] single FU result");
        bus.wb_ready = 1'b1;
        stim_q[1].push_back(make_entry(5, 64'hDEAD, 12));
        run_cycle();
        checkOutput("single_valid", bus.wb_valid, 1'b1);
        checkOutput("single_src", bus.wb_src, 1);
        checkOutput("single_inst", bus.wb_inst_id, 5);
        checkOutput("single_data0", bus.wb_data[0], 64'hDEAD);
        checkOutput("single_prn0", bus.wb_prn[0], 12);
        run_cycle();
        checkOutput("single_empty", bus.wb_valid, 1'b0);

        $display("[TB] fairness");
        flush_cycle();
        for (int n = 0; n < NUM_FU; n++) stim_q[n].push_back(make_entry(10 + n, 64'(n), n));
        run_cycle();
        for (int i = 0; i < NUM_FU; i++) begin
            checkOutput("fair_src", bus.wb_src, i);
            run_cycle();
        end
        checkOutput("fair_empty", bus.wb_valid, 1'b0);

        $display("[TB] backpressure");
        bus.wb_ready = 1'b0;
        for (int k = 0; k < 3; k++) stim_q[2].push_back(make_entry(20 + k, 64'(100 + k), k));
        repeat (2) run_cycle();
        checkOutput("bp_full", bus.fu_ready[2], 1'b0);
        run_cycle();
        checkOutput("bp_held", bus.fu_ready[2], 1'b0);
        checkOutput("bp_head0", bus.wb_inst_id, 20);
        bus.wb_ready = 1'b1;
        run_cycle();
        checkOutput("bp_head1", bus.wb_inst_id, 21);
        run_cycle();
        checkOutput("bp_head2", bus.wb_inst_id, 22);
        run_cycle();
        checkOutput("bp_empty", bus.wb_valid, 1'b0);

        $display("[TB] stall lock");
        flush_cycle();
        bus.wb_ready = 1'b0;
        stim_q[3].push_back(make_entry(33, 64'h3333, 3));
        run_cycle();
        stim_q[0].push_back(make_entry(40, 64'h4040, 4));
        run_cycle();
        checkOutput("lock_src", bus.wb_src, 3);
        checkOutput("lock_inst", bus.wb_inst_id, 33);
        run_cycle();
        checkOutput("lock_src_hold", bus.wb_src, 3);
        bus.wb_ready = 1'b1;
        run_cycle();
        checkOutput("lock_next_src", bus.wb_src, 0);
        checkOutput("lock_next_inst", bus.wb_inst_id, 40);
        run_cycle();

        $display("[TB] flush");
        bus.wb_ready = 1'b0;
        for (int k = 0; k < 2; k++) begin
            stim_q[0].push_back(make_entry(50 + k, 64'(k), k));
            stim_q[1].push_back(make_entry(60 + k, 64'(k), k));
        end
        repeat (2) run_cycle();
        bus.wb_ready = 1'b1;
        flush_cycle();
        checkOutput("flush_valid", bus.wb_valid, 1'b0);
        checkOutput("flush_ready", bus.fu_ready, 4'hF);
        stim_q[2].push_back(make_entry(7, 64'h7777, 7));
        run_cycle();
        checkOutput("flush_new_src", bus.wb_src, 2);
        checkOutput("flush_new_inst", bus.wb_inst_id, 7);
        run_cycle();

        $display("[TB] asynchronous reset");
        bus.wb_ready = 1'b0;
        stim_q[1].push_back(make_entry(11, 64'h11, 1));
        stim_q[2].push_back(make_entry(12, 64'h12, 2));
        repeat (2) run_cycle();
        #2;
        rst = 1'b0;
        #1;
        checkOutput("arst_valid", bus.wb_valid, 1'b0);
        checkOutput("arst_src", bus.wb_src, 0);
        checkOutput("arst_inst", bus.wb_inst_id, 0);
        model_clear();
        for (int n = 0; n < NUM_FU; n++) stim_q[n].delete();
        applyStimulus();
        @(posedge clk);
        #1;
        rst          = 1'b1;
        bus.wb_ready = 1'b1;
        stim_q[3].push_back(make_entry(43, 64'h43, 3));
        stim_q[1].push_back(make_entry(41, 64'h41, 1));
        run_cycle();
        checkOutput("arst_first_src", bus.wb_src, 1);
        run_cycle();
        checkOutput("arst_second_src", bus.wb_src, 3);
        run_cycle();

        $display("[TB] random traffic");
        for (int c = 0; c < 400; c++) begin
            for (int n = 0; n < NUM_FU; n++) begin
                if (stim_q[n].size() < 2 && ($urandom % 2) == 0) stim_q[n].push_back(rand_entry());
            end
            bus.wb_ready = ($urandom % 4) != 0;
            flush        = ($urandom % 40) == 0;
            run_cycle();
        end
        flush        = 1'b0;
        bus.wb_ready = 1'b1;
        repeat (20) run_cycle();
        checkOutput("drain_empty", bus.wb_valid, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/fu_wb_arbiter.md
Name: fu_wb_arbiter

Overview:
- Collects completed results from NUM_FU functional units and funnels them onto one writeback/ROB completion port.
- Each FU channel has a FIFO of FIFO_DEPTH entries; a round-robin arbiter selects among non-empty FIFOs.
- FU and writeback sides both use valid/ready flow control, so an FU stalls instead of dropping a result when writeback is busy.
- Sits between the FU output ports and the register-file writeback / ROB completion logic; supports a synchronous pipeline flush.

Parameters:
- NUM_FU, 4, number of FU result channels (>=2).
- FIFO_DEPTH, 2, entries per channel FIFO (power of two, >=2).
- INST_ID_BITS, 6, instruction ID width.
- PRN_BITS, 6, physical register number width.
- MAX_OPERANDS, 3, result slots per instruction.

Ports:
- clk  in  1  clock, all state on rising edge.
- rst  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous clear of all buffered results.
- fu_valid  in  [NUM_FU]  FU n presents a result.
- fu_ready  out  [NUM_FU]  channel n can accept a result.
- fu_inst_id  in  [NUM_FU][INST_ID_BITS]  result instruction ID.
- fu_prn  in  [NUM_FU][MAX_OPERANDS][PRN_BITS]  destination PRN per slot.
- fu_data  in  [NUM_FU][MAX_OPERANDS][64]  result data per slot.
- fu_data_valid  in  [NUM_FU][MAX_OPERANDS]  slot carries a result.
- wb_valid  out  1  selected result is presented.
- wb_ready  in  1  consumer accepts this cycle.
- wb_inst_id  out  INST_ID_BITS  selected instruction ID.
- wb_prn  out  [MAX_OPERANDS][PRN_BITS]  selected PRNs.
- wb_data  out  [MAX_OPERANDS][64]  selected data.
- wb_data_valid  out  [MAX_OPERANDS]  selected slot valids.
- wb_src  out  $clog2(NUM_FU)  index of the granted channel.

Behaviour:
- Reset (rst low, asynchronous):
  - all FIFOs empty, count=0;
  - RR pointer=0, grant lock cleared;
  - wb_valid=0; fu_ready all 1 once rst deasserts.
  - wb_* payload outputs and wb_src are 0 while wb_valid=0.
- Push rules:
  - fu_ready[n] = (count[n] < FIFO_DEPTH), taken from registered count only; it does not depend on a same-cycle pop.
  - Push happens when fu_valid[n] & fu_ready[n]; the entry is stored at the write pointer.
  - fu_valid asserted while fu_ready=0 is ignored. The FU must hold its payload until accepted.
- Latency: a result pushed into an empty FIFO at edge N is visible on wb_* in the cycle after edge N, i.e. 1 cycle minimum. No combinational path from fu_* to wb_*.
- Arbitration:
  - wb_valid = 1 if any FIFO is non-empty.
  - Grant goes to the first non-empty channel found scanning from the RR pointer upward, modulo NUM_FU.
  - wb_* shows the head entry of the granted FIFO; wb_src = granted index.
- Transfer: on wb_valid & wb_ready, pop the granted FIFO and set RR pointer = (granted+1) mod NUM_FU.
- Stall stability:
  - While wb_valid & !wb_ready, the grant locks. wb_src and all wb_* hold stable next cycle even if a higher-priority channel becomes non-empty.
  - The lock releases on transfer or flush.
- Simultaneous push and pop on the same channel: count unchanged, both pointers advance. A full channel still shows fu_ready=0 that cycle.
- Pointers wrap modulo FIFO_DEPTH. count spans 0..FIFO_DEPTH, width $clog2(FIFO_DEPTH)+1.
- Flush:
  - At the edge with flush=1, all FIFOs empty, RR pointer=0, lock cleared.
  - Pushes and pops in the flush cycle are discarded.
  - wb_valid=0 and fu_ready all 1 the next cycle.
  - flush has priority over every other event.
- Reset mid-transfer: state is cleared immediately. Outputs take reset values asynchronously.
- Payload passes through unmodified. Slots with fu_data_valid=0 are still forwarded, with valid=0.

Test Plan:
- Single FU: channel 1 pushes inst_id=5, data[0]=0xDEAD, prn[0]=12, wb_ready=1 -> next cycle wb_valid=1, wb_src=1, wb_inst_id=5, wb_data[0]=0xDEAD; the following cycle wb_valid=0.
- Fairness: all 4 channels push one result each in the same cycle, wb_ready=1 -> wb_src order 0,1,2,3 on consecutive cycles, then wb_valid=0.
- Backpressure:
  - wb_ready=0; channel 2 pushes 3 results, FIFO_DEPTH=2 -> fu_ready[2]=0 after 2 accepted pushes; the third is held by the FU.
  - Raise wb_ready -> outputs appear in push order and the third push is accepted.
- Stall lock: channel 3 holds an entry, wb_ready=0, then channel 0 pushes -> wb_src stays 3 with identical payload until wb_ready=1; channel 0 drains on the next cycle.
- Flush: 2 entries in each of channels 0 and 1, flush pulsed with wb_ready=1 -> no wb transfer counted; next cycle wb_valid=0 and fu_ready=4'b1111. A new push on channel 2 then emerges with wb_src=2.
- Async reset: assert rst=0 mid-stream with entries buffered -> wb_valid=0 immediately without a clock edge; after release, FIFOs are empty and first grant scanning starts at channel 0.
